// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Package  : cpu_mem_pkg                                                  |
// | Purpose  : Shared constants and types for the CPU RAM port arbiter.     |
// |            RAM geometry, arbiter owner states, requester port indices.  |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
package cpu_mem_pkg;

  // Geometry of the shared single-port program/data RAM (256 x 16).
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  // Requester port indices.
  localparam bit P_CPU = 1'b0;
  localparam bit P_DBG = 1'b1;

  // Owner state: IDLE = arbitrate freely, OWNn = port n holds a lock.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : rr_pick2                                                     |
// | Purpose  : Combinational two-way round-robin pick. With a single        |
// |            requester that port is picked; with both, the port that did  |
// |            not win last time is picked.                                 |
// | Ports    : req[1:0]     in  per-port request                            |
// |            last_winner  in  index of the port granted most recently     |
// |            pick_valid   out at least one request present                |
// |            pick         out index of the picked port                    |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
module rr_pick2
  import cpu_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_winner,
  output logic       pick_valid,
  output logic       pick
);

  always_comb begin
    pick_valid = |req;
    if (req == 2'b11) begin
      pick = ~last_winner;
    end else if (req[P_DBG]) begin
      pick = P_DBG;
    end else begin
      pick = P_CPU;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                             |
// | Purpose  : Shares the single-port program/data RAM between the CPU      |
// |            (port 0) and the debug/loader (port 1). Round-robin pick,    |
// |            bounded lock for read-modify-write, 1-cycle read latency.    |
// | Ports    : clk, reset_n (async, active low)                             |
// |            req/we/lock[1:0]     per-port request, write enable, lock    |
// |            addr0/1, wdata0/1    per-port address and write data         |
// |            gnt[1:0]             one-hot combinational accept            |
// |            rvalid[1:0], rdata   registered read response                |
// |            ram_addr/we/din      RAM command, ram_dout RAM read data     |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W   = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W   = cpu_mem_pkg::DATA_W,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [1:0]        lock,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  import cpu_mem_pkg::*;

  // The lock counter only ever reaches MAX_LOCK-1.
  localparam int              CNT_W       = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CNT_W-1:0] c_lock_last = CNT_W'(MAX_LOCK - 1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_last_winner;
  logic              w_last_winner_nxt;
  logic [CNT_W-1:0]  r_lock_cnt;
  logic [CNT_W-1:0]  w_lock_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_base;
  logic [1:0]        r_rvalid;
  logic [ADDR_W-1:0] r_addr_hold;

  logic              w_pick_valid;
  logic              w_pick;
  logic              w_gnt_valid;
  logic              w_gnt_port;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  rr_pick2 u_rr_pick2 (
    .req         (req),
    .last_winner (r_last_winner),
    .pick_valid  (w_pick_valid),
    .pick        (w_pick)
  );

  // Grant selection and next owner state.
  // A locked owner that still requests is granted outright; if it dropped
  // its request the lock is over and the round-robin pick takes this very
  // cycle, so the other port is not left idling for a cycle.
  always_comb begin
    w_gnt_valid       = 1'b0;
    w_gnt_port        = P_CPU;
    w_cnt_base        = '0;
    w_state_nxt       = IDLE;
    w_lock_cnt_nxt    = '0;
    w_last_winner_nxt = r_last_winner;

    if (r_state == OWN0 && req[P_CPU]) begin
      w_gnt_valid = 1'b1;
      w_gnt_port  = P_CPU;
      w_cnt_base  = r_lock_cnt;
    end else if (r_state == OWN1 && req[P_DBG]) begin
      w_gnt_valid = 1'b1;
      w_gnt_port  = P_DBG;
      w_cnt_base  = r_lock_cnt;
    end else begin
      w_gnt_valid = w_pick_valid;
      w_gnt_port  = w_pick;
    end

    // No accesses at all while reset is held.
    if (!reset_n) begin
      w_gnt_valid = 1'b0;
    end

    if (w_gnt_valid) begin
      w_last_winner_nxt = w_gnt_port;
      // Stay/become owner only while the run is below its bound; the grant
      // that brings the count to MAX_LOCK-1 is the last locked one.
      if (lock[w_gnt_port] && (w_cnt_base < c_lock_last)) begin
        w_state_nxt    = (w_gnt_port == P_DBG) ? OWN1 : OWN0;
        w_lock_cnt_nxt = w_cnt_base + CNT_W'(1);
      end
    end
  end

  assign w_sel_addr  = (w_gnt_port == P_DBG) ? addr1  : addr0;
  assign w_sel_wdata = (w_gnt_port == P_DBG) ? wdata1 : wdata0;

  assign gnt[P_CPU] = w_gnt_valid & (w_gnt_port == P_CPU);
  assign gnt[P_DBG] = w_gnt_valid & (w_gnt_port == P_DBG);

  // Address is held between grants so the RAM input stays quiet.
  assign ram_addr = w_gnt_valid ? w_sel_addr : r_addr_hold;
  assign ram_we   = w_gnt_valid & we[w_gnt_port];
  assign ram_din  = w_gnt_valid ? w_sel_wdata : '0;

  assign rvalid = r_rvalid;
  assign rdata  = ram_dout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_last_winner <= P_DBG;
      r_lock_cnt    <= '0;
      r_rvalid      <= '0;
      r_addr_hold   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_winner <= w_last_winner_nxt;
      r_lock_cnt    <= w_lock_cnt_nxt;
      r_rvalid      <= gnt & ~we;
      if (w_gnt_valid) begin
        r_addr_hold <= w_sel_addr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : tb_mem_port_arbiter                                          |
// | Purpose  : Self-checking bench for mem_port_arbiter. Directed scenarios |
// |            followed by random traffic, checked against a transaction-   |
// |            level reference model and a read-response scoreboard.       |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    req, we, lock;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    gnt, rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .lock(lock),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Synchronous single-port RAM attached to the arbiter.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  // ---------------- checking infrastructure ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    bit            known;
  } exp_t;
  exp_t sbq[$];

  // Reference model: transaction-level view of ownership.
  int            m_owner;      // -1 = nobody holds a lock
  int            m_run;        // grants in the current ownership run
  int            m_last;       // port granted most recently
  logic [1:0]    m_rvalid;     // read responses due this cycle
  logic [AW-1:0] m_hold;
  bit            m_hold_ok;
  logic [DW-1:0] ref_mem [256];
  bit            ref_known [256];

  // Per-port pending transaction, held on the bus until granted.
  bit            pend [2];
  bit            pwe [2];
  bit            plock [2];
  logic [AW-1:0] paddr [2];
  logic [DW-1:0] pwd [2];
  logic          rst_val;
  logic [1:0]    s_gnt;

  task automatic model_reset();
    m_owner = -1; m_run = 0; m_last = 1; m_rvalid = 2'b00; m_hold_ok = 0;
    sbq.delete();
  endtask

  task automatic set_txn(input int p, input bit w, input bit l, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    pend[p] = 1; pwe[p] = w; plock[p] = l; paddr[p] = a; pwd[p] = d;
  endtask

  task automatic gen_random();
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && $urandom_range(0, 99) < 60)
        set_txn(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 35),
                AW'($urandom_range(0, 15)), DW'($urandom));
    end
  endtask

  task automatic step_check();
    int p;
    if (reset_n !== 1'b1) begin
      model_reset();
      check("rst_gnt", gnt, 2'b00);
      check("rst_ram_we", ram_we, 1'b0);
      check("rst_rvalid", rvalid, 2'b00);
      s_gnt = gnt;
      return;
    end
    check("rvalid", rvalid, m_rvalid);
    p = -1;
    if (m_owner >= 0 && pend[m_owner]) p = m_owner;
    else if (pend[0] && pend[1])       p = (m_last == 0) ? 1 : 0;
    else if (pend[0])                  p = 0;
    else if (pend[1])                  p = 1;
    s_gnt = gnt;
    if (p >= 0) begin
      check("gnt", gnt, 32'(1) << p);
      m_run = (p == m_owner) ? m_run + 1 : 1;
      if (plock[p] && m_run < ML) m_owner = p;
      else begin m_owner = -1; m_run = 0; end
      m_last = p;
      check("ram_addr", ram_addr, paddr[p]);
      check("ram_we", ram_we, pwe[p]);
      if (pwe[p]) begin
        check("ram_din", ram_din, pwd[p]);
        ref_mem[paddr[p]] = pwd[p];
        ref_known[paddr[p]] = 1;
        m_rvalid = 2'b00;
      end else begin
        sbq.push_back('{port: p, data: ref_mem[paddr[p]], known: ref_known[paddr[p]]});
        m_rvalid = 2'(32'(1) << p);
      end
      m_hold = paddr[p]; m_hold_ok = 1;
      pend[p] = 0;
    end else begin
      check("gnt_idle", gnt, 2'b00);
      check("ram_we_idle", ram_we, 1'b0);
      if (m_hold_ok) check("ram_addr_hold", ram_addr, m_hold);
      m_owner = -1; m_run = 0;
      m_rvalid = 2'b00;
    end
  endtask

  task automatic run_cycle(input bit rnd);
    @(posedge clk); #1;
    reset_n = rst_val;
    if (rnd) gen_random();
    req    = {pend[1], pend[0]};
    we     = {pwe[1], pwe[0]};
    lock   = {plock[1], plock[0]};
    addr0  = paddr[0]; addr1 = paddr[1];
    wdata0 = pwd[0];   wdata1 = pwd[1];
    #3;
    step_check();
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && (pend[0] || pend[1]); i++) run_cycle(0);
    check("drain", {pend[1], pend[0]}, 2'b00);
    run_cycle(0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && rvalid !== 2'b00) begin
        if (sbq.size() == 0) begin
          check("rvalid_unexpected", rvalid, 2'b00);
        end else begin
          e = sbq.pop_front();
          check("rsp_port", rvalid, 32'(1) << e.port);
          if (e.known) check("rsp_data", rdata, e.data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    logic [1:0] prev;
    for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; ref_known[i] = 0; end
    for (int i = 0; i < 2; i++) begin pend[i] = 0; pwe[i] = 0; plock[i] = 0; paddr[i] = '0; pwd[i] = '0; end
    reset_n = 1'b0; rst_val = 1'b0;
    req = '0; we = '0; lock = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    model_reset();

    // 1: reset, first tie goes to port 0, reset in the middle of a read.
    set_txn(0, 0, 0, 8'h01, '0); set_txn(1, 0, 0, 8'h02, '0);
    run_cycle(0); run_cycle(0);
    rst_val = 1'b1;
    run_cycle(0);
    check("first_tie", s_gnt, 2'b01);
    drain();
    set_txn(0, 0, 0, 8'h03, '0);
    run_cycle(0);
    set_txn(1, 0, 0, 8'h04, '0);
    rst_val = 1'b0;
    run_cycle(0);
    set_txn(0, 0, 0, 8'h05, '0);
    rst_val = 1'b1;
    run_cycle(0);
    check("tie_after_reset", s_gnt, 2'b01);
    drain();

    // 2: port 1 writes, port 0 reads the same word the next cycle.
    set_txn(1, 1, 0, 8'h10, 16'hBEEF);
    run_cycle(0);
    set_txn(0, 0, 0, 8'h10, '0);
    run_cycle(0);
    check("raw_gnt0", s_gnt, 2'b01);
    run_cycle(0);
    check("raw_rvalid0", rvalid, 2'b01);
    check("raw_rdata", rdata, 16'hBEEF);

    // 3: both ports read continuously; grants alternate.
    prev = 2'b00;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 2; k++)
        if (!pend[k]) set_txn(k, 0, 0, AW'(8'h10 + i), '0);
      run_cycle(0);
      if (i > 0) check("alternate", s_gnt, {prev[0], prev[1]});
      prev = s_gnt;
    end
    pend[0] = 0; pend[1] = 0;
    drain();

    // 4: port 1 locked with port 0 waiting -> exactly ML grants to port 1.
    set_txn(0, 0, 0, 8'h20, '0);
    run_cycle(0);
    set_txn(0, 0, 0, 8'h21, '0);
    cnt = 0;
    for (int i = 0; i < 12 && pend[0]; i++) begin
      if (!pend[1]) set_txn(1, 0, 1, AW'(8'h30 + i), '0);
      run_cycle(0);
      if (s_gnt == 2'b10) cnt++;
    end
    check("lock_run", cnt, ML);
    check("lock_release_gnt0", s_gnt, 2'b01);
    pend[1] = 0;
    drain();

    // 5: port 0 locks, drops its request after two grants.
    set_txn(1, 0, 0, 8'h40, '0);
    run_cycle(0);
    set_txn(0, 1, 1, 8'h41, 16'h1234); set_txn(1, 0, 0, 8'h42, '0);
    run_cycle(0);
    check("lock0_first", s_gnt, 2'b01);
    set_txn(0, 0, 1, 8'h41, '0);
    run_cycle(0);
    check("lock0_second", s_gnt, 2'b01);
    run_cycle(0);
    check("unlock_next", s_gnt, 2'b10);
    drain();

    // 6: idle for 10 cycles.
    for (int i = 0; i < 10; i++) run_cycle(0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst_val = ($urandom_range(0, 199) != 0);
      run_cycle(1);
    end
    rst_val = 1'b1;
    drain();
    run_cycle(0);
    check("sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
